// File: rtl/prog_ctr_ras.sv
// Program counter with relative branch, absolute jump, sticky halt, saturating cycle counter
// and an optional call/return stack enabled by the PROG_CTR_RAS_EN macro.
module prog_ctr_ras #(
  parameter int unsigned AW        = 10,
  parameter int unsigned OW        = 6,
  parameter int unsigned SD        = 4,
  parameter int unsigned RESET_VEC = 0,
  parameter int unsigned CW        = 16
) (
  input  logic                     CLK,
  input  logic                     start,
  input  logic                     stall,
  input  logic                     jump_en,
  input  logic                     branch_en,
  input  logic                     call_en,
  input  logic                     ret_en,
  input  logic                     halt_req,
  input  logic [AW-1:0]            destination,
  input  logic [OW-1:0]            offset,
  output logic [AW-1:0]            PC,
  output logic                     halt,
  output logic                     stk_ovf,
  output logic                     stk_unf,
  output logic [$clog2(SD+1)-1:0]  depth,
  output logic [CW-1:0]            cycle_ct
);

  localparam int unsigned DW = $clog2(SD + 1);

  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_nxt;
  logic          r_halt;
  logic          w_halt_nxt;
  logic [CW-1:0] r_ct;
  logic [CW-1:0] w_ct_nxt;
  logic [AW-1:0] w_pc_inc;
  logic [AW-1:0] w_pc_br;

  assign w_pc_inc = r_pc + AW'(1);
  assign w_pc_br  = r_pc + AW'($signed(offset));

  // Counts every edge while running, saturating at all-ones.
  assign w_ct_nxt = (r_halt || (&r_ct)) ? r_ct : r_ct + CW'(1);

`ifdef PROG_CTR_RAS_EN
  localparam int unsigned IW = (SD > 1) ? $clog2(SD) : 1;

  logic [AW-1:0] r_stack [SD];
  logic [DW-1:0] r_depth;
  logic [DW-1:0] w_depth_nxt;
  logic          r_ovf;
  logic          w_ovf_nxt;
  logic          r_unf;
  logic          w_unf_nxt;
  logic          w_push;
  logic [IW-1:0] w_push_idx;
  logic [IW-1:0] w_top_idx;

  assign w_push_idx = IW'(r_depth);
  assign w_top_idx  = IW'(r_depth - DW'(1));

  // Next-state selection in strobe priority order.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_halt_nxt  = r_halt;
    w_depth_nxt = r_depth;
    w_ovf_nxt   = r_ovf;
    w_unf_nxt   = r_unf;
    w_push      = 1'b0;
    if (r_halt) begin
      w_pc_nxt = r_pc;
    end else if (halt_req) begin
      w_halt_nxt = 1'b1;
    end else if (stall) begin
      w_pc_nxt = r_pc;
    end else if (ret_en) begin
      if (r_depth != DW'(0)) begin
        w_pc_nxt    = r_stack[w_top_idx];
        w_depth_nxt = r_depth - DW'(1);
      end else begin
        w_unf_nxt  = 1'b1;
        w_halt_nxt = 1'b1;
      end
    end else if (call_en) begin
      if (r_depth != DW'(SD)) begin
        w_push      = 1'b1;
        w_depth_nxt = r_depth + DW'(1);
        w_pc_nxt    = destination;
      end else begin
        w_ovf_nxt  = 1'b1;
        w_halt_nxt = 1'b1;
      end
    end else if (jump_en) begin
      w_pc_nxt = destination;
    end else if (branch_en) begin
      w_pc_nxt = w_pc_br;
    end else begin
      w_pc_nxt = w_pc_inc;
    end
  end

  always_ff @(posedge CLK or posedge start) begin
    if (start) begin
      r_pc    <= AW'(RESET_VEC);
      r_halt  <= 1'b0;
      r_ct    <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_halt  <= w_halt_nxt;
      r_ct    <= w_ct_nxt;
      r_depth <= w_depth_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  // Stack contents need no reset; depth alone tracks validity.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  assign stk_ovf = r_ovf;
  assign stk_unf = r_unf;
  assign depth   = r_depth;
`else
  logic w_unused;

  assign w_unused = ret_en;

  // Next-state selection; call behaves as a jump when no stack is built.
  always_comb begin
    w_pc_nxt   = r_pc;
    w_halt_nxt = r_halt;
    if (r_halt) begin
      w_pc_nxt = r_pc;
    end else if (halt_req) begin
      w_halt_nxt = 1'b1;
    end else if (stall) begin
      w_pc_nxt = r_pc;
    end else if (call_en || jump_en) begin
      w_pc_nxt = destination;
    end else if (branch_en) begin
      w_pc_nxt = w_pc_br;
    end else begin
      w_pc_nxt = w_pc_inc;
    end
  end

  always_ff @(posedge CLK or posedge start) begin
    if (start) begin
      r_pc   <= AW'(RESET_VEC);
      r_halt <= 1'b0;
      r_ct   <= '0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_halt <= w_halt_nxt;
      r_ct   <= w_ct_nxt;
    end
  end

  assign stk_ovf = 1'b0;
  assign stk_unf = 1'b0;
  assign depth   = DW'(0);
`endif

  assign PC       = r_pc;
  assign halt     = r_halt;
  assign cycle_ct = r_ct;

endmodule

// File: tb/tb_prog_ctr_ras.sv
// Directed bench for prog_ctr_ras; expectations follow PROG_CTR_RAS_EN when defined.
module tb_prog_ctr_ras;

  logic        CLK;
  logic        start;
  logic        stall;
  logic        jump_en;
  logic        branch_en;
  logic        call_en;
  logic        ret_en;
  logic        halt_req;
  logic [9:0]  destination;
  logic [5:0]  offset;
  logic [9:0]  PC;
  logic        halt;
  logic        stk_ovf;
  logic        stk_unf;
  logic [2:0]  depth;
  logic [15:0] cycle_ct;

  int total;
  int bad;

  prog_ctr_ras #(.AW(10), .OW(6), .SD(4), .RESET_VEC(0), .CW(16)) dut (
    .CLK(CLK), .start(start), .stall(stall), .jump_en(jump_en), .branch_en(branch_en),
    .call_en(call_en), .ret_en(ret_en), .halt_req(halt_req), .destination(destination),
    .offset(offset), .PC(PC), .halt(halt), .stk_ovf(stk_ovf), .stk_unf(stk_unf),
    .depth(depth), .cycle_ct(cycle_ct)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic clear_in();
    stall = 0; jump_en = 0; branch_en = 0; call_en = 0; ret_en = 0; halt_req = 0;
    destination = '0; offset = '0;
  endtask

  // One active edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    clear_in();
    start = 1;
    @(negedge CLK);
    start = 0;
  endtask

  task automatic do_jump(input logic [9:0] d);
    jump_en = 1; destination = d;
    tick();
    clear_in();
  endtask

  task automatic test_reset();
    start = 1;
    clear_in();
    #12;
    total++; if (PC !== 10'd0) begin bad++; $display("FAIL reset_pc got=%0d want=0", PC); end
    total++; if ({halt, stk_ovf, stk_unf} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {halt, stk_ovf, stk_unf}); end
    total++; if (depth !== 3'd0 || cycle_ct !== 16'd0) begin bad++; $display("FAIL reset_cnt depth=%0d ct=%0d want 0/0", depth, cycle_ct); end
    @(negedge CLK);
    start = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      total++; if (PC !== 10'(i)) begin bad++; $display("FAIL idle_pc got=%0d want=%0d", PC, i); end
    end
    total++; if (cycle_ct !== 16'd5) begin bad++; $display("FAIL idle_ct got=%0d want=5", cycle_ct); end
  endtask

  task automatic test_async_reset();
    tick();
    #2;
    start = 1;
    #1;
    total++; if (PC !== 10'd0 || cycle_ct !== 16'd0) begin bad++; $display("FAIL async_rst pc=%0d ct=%0d want 0/0", PC, cycle_ct); end
    @(negedge CLK);
    start = 0;
    tick();
    total++; if (PC !== 10'd1) begin bad++; $display("FAIL resume_pc got=%0d want=1", PC); end
  endtask

  task automatic test_wrap_branch();
    do_reset();
    do_jump(10'd1023);
    total++; if (PC !== 10'd1023) begin bad++; $display("FAIL jump_pc got=%0d want=1023", PC); end
    tick();
    total++; if (PC !== 10'd0) begin bad++; $display("FAIL wrap_pc got=%0d want=0", PC); end
    do_jump(10'd5);
    branch_en = 1; offset = 6'b111100;
    tick();
    clear_in();
    total++; if (PC !== 10'd1) begin bad++; $display("FAIL branch_neg got=%0d want=1", PC); end
    branch_en = 1; offset = 6'd6;
    tick();
    clear_in();
    total++; if (PC !== 10'd7) begin bad++; $display("FAIL branch_pos got=%0d want=7", PC); end
    do_jump(10'd2);
    branch_en = 1; offset = 6'b111101;
    tick();
    clear_in();
    total++; if (PC !== 10'd1023) begin bad++; $display("FAIL branch_wrap got=%0d want=1023", PC); end
  endtask

  task automatic test_call_ovf();
    logic [9:0] dests [4];
    dests[0] = 10'd100; dests[1] = 10'd200; dests[2] = 10'd300; dests[3] = 10'd400;
    do_reset();
    do_jump(10'd10);
    for (int i = 0; i < 4; i++) begin
      call_en = 1; destination = dests[i];
      tick();
      clear_in();
      total++; if (PC !== dests[i]) begin bad++; $display("FAIL call_pc got=%0d want=%0d", PC, dests[i]); end
`ifdef PROG_CTR_RAS_EN
      total++; if (depth !== 3'(i + 1)) begin bad++; $display("FAIL call_depth got=%0d want=%0d", depth, i + 1); end
`else
      total++; if (depth !== 3'd0) begin bad++; $display("FAIL call_depth got=%0d want=0", depth); end
`endif
    end
    call_en = 1; destination = 10'd500;
    tick();
    clear_in();
    tick();
`ifdef PROG_CTR_RAS_EN
    total++; if (PC !== 10'd400 || depth !== 3'd4) begin bad++; $display("FAIL ovf_pc pc=%0d depth=%0d want 400/4", PC, depth); end
    total++; if ({stk_ovf, halt, stk_unf} !== 3'b110) begin bad++; $display("FAIL ovf_flags got=%b want=110", {stk_ovf, halt, stk_unf}); end
    total++; if (cycle_ct !== 16'd6) begin bad++; $display("FAIL ovf_ct got=%0d want=6", cycle_ct); end
`else
    total++; if (PC !== 10'd501 || {stk_ovf, halt} !== 2'b00) begin bad++; $display("FAIL ovf_pc pc=%0d flags=%b want 501/00", PC, {stk_ovf, halt}); end
`endif
  endtask

  task automatic test_ret_chain();
    logic [9:0] dests [4];
    logic [9:0] rets [4];
    dests[0] = 10'd100; dests[1] = 10'd200; dests[2] = 10'd300; dests[3] = 10'd400;
`ifdef PROG_CTR_RAS_EN
    rets[0] = 10'd301; rets[1] = 10'd201; rets[2] = 10'd101; rets[3] = 10'd11;
`else
    rets[0] = 10'd401; rets[1] = 10'd402; rets[2] = 10'd403; rets[3] = 10'd404;
`endif
    do_reset();
    do_jump(10'd10);
    for (int i = 0; i < 4; i++) begin
      call_en = 1; destination = dests[i];
      tick();
      clear_in();
    end
    for (int i = 0; i < 4; i++) begin
      ret_en = 1;
      tick();
      clear_in();
      total++; if (PC !== rets[i]) begin bad++; $display("FAIL ret_pc got=%0d want=%0d", PC, rets[i]); end
    end
    total++; if (depth !== 3'd0 || halt !== 1'b0) begin bad++; $display("FAIL ret_end depth=%0d halt=%b want 0/0", depth, halt); end
  endtask

  task automatic test_underflow();
    do_reset();
    tick();
    tick();
    ret_en = 1;
    tick();
    clear_in();
    tick(); tick(); tick();
`ifdef PROG_CTR_RAS_EN
    total++; if ({stk_unf, halt, stk_ovf} !== 3'b110) begin bad++; $display("FAIL unf_flags got=%b want=110", {stk_unf, halt, stk_ovf}); end
    total++; if (PC !== 10'd2 || cycle_ct !== 16'd3) begin bad++; $display("FAIL unf_freeze pc=%0d ct=%0d want 2/3", PC, cycle_ct); end
`else
    total++; if ({stk_unf, halt} !== 2'b00) begin bad++; $display("FAIL unf_flags got=%b want=00", {stk_unf, halt}); end
    total++; if (PC !== 10'd6 || cycle_ct !== 16'd6) begin bad++; $display("FAIL unf_run pc=%0d ct=%0d want 6/6", PC, cycle_ct); end
`endif
  endtask

  task automatic test_priority();
    do_reset();
    do_jump(10'd50);
    call_en = 1; destination = 10'd60;
    tick();
    clear_in();
    ret_en = 1; call_en = 1; jump_en = 1; destination = 10'd70;
    tick();
    clear_in();
`ifdef PROG_CTR_RAS_EN
    total++; if (PC !== 10'd51 || depth !== 3'd0) begin bad++; $display("FAIL prio_ret pc=%0d depth=%0d want 51/0", PC, depth); end
`else
    total++; if (PC !== 10'd70) begin bad++; $display("FAIL prio_ret pc=%0d want 70", PC); end
`endif
    stall = 1; jump_en = 1; destination = 10'd90;
    tick();
    clear_in();
`ifdef PROG_CTR_RAS_EN
    total++; if (PC !== 10'd51) begin bad++; $display("FAIL stall_pc got=%0d want=51", PC); end
`else
    total++; if (PC !== 10'd70) begin bad++; $display("FAIL stall_pc got=%0d want=70", PC); end
`endif
    total++; if (cycle_ct !== 16'd4) begin bad++; $display("FAIL stall_ct got=%0d want=4", cycle_ct); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_jump(10'd20);
    call_en = 1; destination = 10'd40;
    tick();
    clear_in();
    ret_en = 1;
    tick();
    clear_in();
    call_en = 1; destination = 10'd60;
    tick();
    clear_in();
    ret_en = 1;
    tick();
    clear_in();
`ifdef PROG_CTR_RAS_EN
    total++; if (PC !== 10'd22 || depth !== 3'd0) begin bad++; $display("FAIL b2b_pc pc=%0d depth=%0d want 22/0", PC, depth); end
`else
    total++; if (PC !== 10'd61) begin bad++; $display("FAIL b2b_pc pc=%0d want 61", PC); end
`endif
  endtask

  task automatic test_halt();
    do_reset();
    do_jump(10'd7);
    halt_req = 1;
    tick();
    clear_in();
    total++; if (halt !== 1'b1 || PC !== 10'd7) begin bad++; $display("FAIL halt_set halt=%b pc=%0d want 1/7", halt, PC); end
    total++; if (cycle_ct !== 16'd2) begin bad++; $display("FAIL halt_ct got=%0d want=2", cycle_ct); end
    jump_en = 1; destination = 10'd300;
    for (int i = 0; i < 10; i++) tick();
    clear_in();
    total++; if (PC !== 10'd7 || halt !== 1'b1 || cycle_ct !== 16'd2) begin bad++; $display("FAIL halt_hold pc=%0d halt=%b ct=%0d want 7/1/2", PC, halt, cycle_ct); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_async_reset();
    test_wrap_branch();
    test_call_ovf();
    test_ret_chain();
    test_underflow();
    test_priority();
    test_back_to_back();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
